// File: rtl/enigma_stream_if.sv
// Valid/ready byte stream bundle for the enigma decoder: input side and output side.
// The master modport is the environment, the slave modport is the decoder.
interface enigma_stream_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/enigma_stream_decoder.sv
// Streaming enigma decoder: steps a 2-bit setting through a loaded key schedule, one
// step per letter, through a single registered output stage on valid/ready.
module enigma_stream_decoder #(
  parameter int unsigned KEY_LEN = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_key_load,
  input  logic [2*KEY_LEN-1:0] i_key,
  enigma_stream_if.slave       io_stream,
  output logic                 o_key_valid,
  output logic [CNT_W-1:0]     o_char_cnt
);
  localparam int unsigned IDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Reflector per setting: character n is the partner of letter 'A'+n (all involutions).
  localparam logic [26*8-1:0] TBL_S0 = "OCBEDGFIHKJYNMAQPSRUTWVZLX";
  localparam logic [26*8-1:0] TBL_S1 = "BADCSGFIHLWJNMPORQEUTXKVZY";
  localparam logic [26*8-1:0] TBL_S2 = "BAHLFEOCJIMDKPGNRQTSVUXWZY";
  localparam logic [26*8-1:0] TBL_S3 = "BADCFEIRGKJQNMPOLHTSVUXWZY";

  function automatic logic [7:0] f_core(input logic [7:0] ch, input logic [1:0] setting);
    logic [26*8-1:0] tbl;
    logic [7:0]      pos;
    case (setting)
      2'd0:    tbl = TBL_S0;
      2'd1:    tbl = TBL_S1;
      2'd2:    tbl = TBL_S2;
      default: tbl = TBL_S3;
    endcase
    pos = ch - 8'h41;
    if (pos > 8'd25) return ch;
    return tbl[8*(25 - int'(pos)) +: 8];
  endfunction

  logic [1:0]         r_state;
  logic [2*KEY_LEN-1:0] r_key;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_out_valid;
  logic [7:0]         r_out_data;
  logic               r_out_last;

  logic               w_key_valid;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_is_letter;
  logic [1:0]         w_setting;
  logic [IDX_W-1:0]   w_idx_next;
  logic [7:0]         w_mapped;
  logic [1:0]         w_state_next;

  always_comb begin
    w_key_valid  = (r_state != ST_IDLE);
    w_in_ready   = i_rst_n & w_key_valid & ~i_key_load & (~r_out_valid | io_stream.out_ready);
    w_accept     = io_stream.in_valid & w_in_ready;
    w_is_letter  = (io_stream.in_data >= 8'h41) && (io_stream.in_data <= 8'h5A);
    // Slot 0 sits in the top bits of the key word.
    w_setting    = r_key[2*KEY_LEN-1 - 2*r_idx -: 2];
    w_idx_next   = (r_idx == IDX_W'(KEY_LEN - 1)) ? '0 : r_idx + 1'b1;
    w_mapped     = w_is_letter ? f_core(io_stream.in_data, w_setting) : io_stream.in_data;
    w_state_next = ((w_accept | r_out_valid) & ~io_stream.out_ready) ? ST_HOLD : ST_RUN;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_key       <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
      r_out_last  <= 1'b0;
    end else if (i_key_load) begin
      r_state     <= ST_RUN;
      r_key       <= i_key;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else if (r_state != ST_IDLE) begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_mapped;
        r_out_last  <= io_stream.in_last;
        if (w_is_letter) r_cnt <= r_cnt + 1'b1;
        if (io_stream.in_last)  r_idx <= '0;
        else if (w_is_letter)   r_idx <= w_idx_next;
      end else if (io_stream.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign io_stream.in_ready  = w_in_ready;
  assign io_stream.out_valid = r_out_valid;
  assign io_stream.out_data  = r_out_data;
  assign io_stream.out_last  = r_out_last;
  assign o_key_valid         = w_key_valid;
  assign o_char_cnt          = r_cnt;
endmodule

// File: tb/tb_enigma_stream_decoder.sv
// Bench for enigma_stream_decoder: cycle table for the basic stream, directed corner
// sequences, and randomized streams checked against a pair-list reference model.
module tb_enigma_stream_decoder;
  logic        clk;
  logic        rst_n;
  logic        key_load;
  logic [7:0]  key;
  logic        key_valid;
  logic [15:0] char_cnt;

  enigma_stream_if sif ();

  enigma_stream_decoder #(.KEY_LEN(4), .CNT_W(16)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_key_load (key_load),
    .i_key      (key),
    .io_stream  (sif),
    .o_key_valid(key_valid),
    .o_char_cnt (char_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] got[$];
  logic [8:0] exp_q[$];

  // Letter pairs exchanged under each setting.
  string pairs [4] = '{"YLAOBCDEFGHIJKMNPQRSTUVWXZ", "SEKWCDABFGHIJLMNOPQRTUVXYZ",
                       "CHGODLABEFIJKMNPQRSTUVWXYZ", "QLHRABCDEFGIJKMNOPSTUVWXYZ"};
  logic [7:0] m_key;
  int         m_idx;
  int         m_cnt;

  always @(negedge clk)
    if (rst_n && sif.out_valid && sif.out_ready) got.push_back({sif.out_last, sif.out_data});

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_map(input logic [7:0] c, input int s);
    string p = pairs[s];
    for (int j = 0; j < 26; j++)
      if (p[j] == c) return p[j ^ 1];
    return c;
  endfunction

  function automatic void model_push(input string s, input int last_pos);
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0] c = s[i];
      logic [7:0] o = c;
      if (c >= 8'h41 && c <= 8'h5A) begin
        o = model_map(c, int'((m_key >> (2 * (3 - m_idx))) & 8'h03));
        m_idx = (m_idx + 1) % 4;
        m_cnt++;
      end
      if (i == last_pos) m_idx = 0;
      exp_q.push_back({i == last_pos, o});
    end
  endfunction

  function automatic void lit_exp(input string s, input int last_pos);
    for (int i = 0; i < s.len(); i++) exp_q.push_back({i == last_pos, s[i]});
  endfunction

  task automatic cmp_q(input string name);
    chk({name, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk(name, {23'b0, got[i]}, {23'b0, exp_q[i]});
    got.delete();
    exp_q.delete();
  endtask

  task automatic do_key_load(input logic [7:0] k);
    sif.in_valid = 1'b0;
    key_load = 1'b1;
    key = k;
    @(posedge clk); #1;
    key_load = 1'b0;
    m_key = k;
    m_idx = 0;
    m_cnt = 0;
  endtask

  task automatic run_stream(input string s, input int last_pos, input int rdy_pct,
                            input int gap_pct);
    int i = 0;
    int cyc = 0;
    bit acc;
    while ((i < s.len() || sif.out_valid) && cyc < 1000) begin
      if (i < s.len() && int'($urandom_range(99)) >= gap_pct) begin
        sif.in_valid = 1'b1;
        sif.in_data  = s[i];
        sif.in_last  = (i == last_pos);
      end else begin
        sif.in_valid = 1'b0;
        sif.in_last  = 1'b0;
      end
      sif.out_ready = (int'($urandom_range(99)) < rdy_pct);
      @(negedge clk);
      acc = sif.in_valid && sif.in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    sif.in_valid = 1'b0;
    sif.in_last = 1'b0;
    sif.out_ready = 1'b1;
    chk("stream_done", {31'b0, cyc < 1000}, 32'd1);
  endtask

  function automatic string rand_msg(input int n);
    string s = "";
    string punct = " .,!0?";
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(99) < 75) s = {s, $sformatf("%c", 8'h41 + $urandom_range(25))};
      else s = {s, $sformatf("%c", punct[$urandom_range(5)])};
    end
    return s;
  endfunction

  typedef struct {
    logic       kl;
    logic       iv;
    logic [7:0] id;
    logic       xr;
    logic       xv;
    logic [7:0] xd;
    logic [15:0] xc;
    logic       xk;
  } vec_t;

  vec_t tbl [13];

  initial begin
    string cipher = "CSYQGKAHDC";
    string plain  = "HELLOWORLD";
    int    stall;
    int    i;
    int    cyc;
    bit    acc;

    rst_n = 1'b0; key_load = 1'b0; key = 8'h00;
    sif.in_valid = 1'b1; sif.in_data = 8'h41; sif.in_last = 1'b0; sif.out_ready = 1'b1;
    m_key = 8'h00; m_idx = 0; m_cnt = 0;

    // Basic stream, one vector per clock: key_load, ten letters, drain.
    for (int k = 0; k < 13; k++) begin
      tbl[k].kl = (k == 0);
      tbl[k].iv = (k >= 1 && k <= 10);
      tbl[k].id = (k >= 1 && k <= 10) ? cipher[k-1] : 8'h00;
      tbl[k].xr = (k != 0);
      tbl[k].xv = (k >= 2 && k <= 11);
      tbl[k].xd = (k >= 2 && k <= 11) ? plain[k-2] : 8'h00;
      tbl[k].xc = (k == 0) ? 16'd0 : (k >= 11 ? 16'd10 : 16'(k - 1));
      tbl[k].xk = (k != 0);
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, sif.out_valid}, 32'd0);
    chk("rst_key_valid", {31'b0, key_valid}, 32'd0);
    chk("rst_char_cnt", {16'b0, char_cnt}, 32'd0);
    chk("rst_in_ready", {31'b0, sif.in_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("nokey_in_ready", {31'b0, sif.in_ready}, 32'd0);
    @(posedge clk); #1;

    for (int k = 0; k < 13; k++) begin
      key_load = tbl[k].kl;
      key = 8'h93;
      sif.in_valid = tbl[k].iv;
      sif.in_data = tbl[k].id;
      sif.in_last = 1'b0;
      sif.out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("t1_in_ready[%0d]", k), {31'b0, sif.in_ready}, {31'b0, tbl[k].xr});
      chk($sformatf("t1_out_valid[%0d]", k), {31'b0, sif.out_valid}, {31'b0, tbl[k].xv});
      if (tbl[k].xv) chk($sformatf("t1_out_data[%0d]", k), {24'b0, sif.out_data},
                         {24'b0, tbl[k].xd});
      chk($sformatf("t1_cnt[%0d]", k), {16'b0, char_cnt}, {16'b0, tbl[k].xc});
      chk($sformatf("t1_key_valid[%0d]", k), {31'b0, key_valid}, {31'b0, tbl[k].xk});
      @(posedge clk); #1;
    end
    got.delete();

    do_key_load(8'h93);
    run_stream("HELLOWORLD", -1, 70, 20);
    lit_exp("CSYQGKAHDC", -1);
    cmp_q("t2_invol");
    chk("t2_cnt", {16'b0, char_cnt}, 32'd10);

    do_key_load(8'h93);
    run_stream("HE LLO", -1, 100, 0);
    lit_exp("CS YQG", -1);
    cmp_q("t3_space");
    chk("t3_cnt", {16'b0, char_cnt}, 32'd5);

    do_key_load(8'h93);
    run_stream("HEL", 1, 60, 30);
    lit_exp("CSD", 1);
    cmp_q("t4_last");

    // Stall the sink for three clocks while the fourth output is presented.
    do_key_load(8'h93);
    i = 0; cyc = 0; stall = 0;
    while ((i < 10 || sif.out_valid) && cyc < 200) begin
      sif.in_valid = (i < 10);
      sif.in_data = (i < 10) ? cipher[i] : 8'h00;
      sif.in_last = 1'b0;
      if (got.size() == 3 && stall < 3) begin
        sif.out_ready = 1'b0;
        stall++;
      end else begin
        sif.out_ready = 1'b1;
      end
      @(negedge clk);
      acc = sif.in_valid && sif.in_ready;
      if (!sif.out_ready) begin
        chk("t5_hold_data", {24'b0, sif.out_data}, {24'b0, 8'h4C});
        chk("t5_hold_in_ready", {31'b0, sif.in_ready}, 32'd0);
      end
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    sif.in_valid = 1'b0;
    chk("t5_stalls", stall, 32'd3);
    lit_exp(plain, -1);
    cmp_q("t5_stream");

    // key_load beats a valid input byte and flushes the pending output.
    do_key_load(8'h93);
    sif.in_valid = 1'b1; sif.in_data = "C"; sif.out_ready = 1'b0;
    @(posedge clk); #1;
    key_load = 1'b1; key = 8'h93; sif.in_data = "S";
    @(negedge clk);
    chk("t6_in_ready", {31'b0, sif.in_ready}, 32'd0);
    @(posedge clk); #1;
    key_load = 1'b0; sif.in_valid = 1'b0; sif.out_ready = 1'b1;
    @(negedge clk);
    chk("t6_out_valid", {31'b0, sif.out_valid}, 32'd0);
    chk("t6_cnt", {16'b0, char_cnt}, 32'd0);
    got.delete();
    @(posedge clk); #1;
    run_stream("C", -1, 100, 0);
    lit_exp("H", -1);
    cmp_q("t6_idx0");

    // Randomized streams against the reference model.
    for (int it = 0; it < 10; it++) begin
      do_key_load(8'($urandom));
      for (int m = 0; m < 3; m++) begin
        string s = rand_msg(1 + $urandom_range(19));
        int lp = ($urandom_range(1) == 1) ? s.len() - 1 : -1;
        model_push(s, lp);
        run_stream(s, lp, 30 + $urandom_range(70), $urandom_range(50));
      end
      cmp_q($sformatf("rnd%0d", it));
      chk($sformatf("rnd%0d_cnt", it), {16'b0, char_cnt}, 32'(m_cnt));
    end

    // Reset mid-stream with a pending output.
    do_key_load(8'h93);
    sif.in_valid = 1'b1; sif.in_data = "C"; sif.out_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; sif.in_data = "S";
    @(negedge clk);
    chk("t7_in_ready_rst", {31'b0, sif.in_ready}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t7_out_valid", {31'b0, sif.out_valid}, 32'd0);
    chk("t7_out_data", {24'b0, sif.out_data}, 32'd0);
    chk("t7_out_last", {31'b0, sif.out_last}, 32'd0);
    chk("t7_key_valid", {31'b0, key_valid}, 32'd0);
    chk("t7_cnt", {16'b0, char_cnt}, 32'd0);
    sif.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("t7_ignore_ready", {31'b0, sif.in_ready}, 32'd0);
      chk("t7_ignore_valid", {31'b0, sif.out_valid}, 32'd0);
    end
    sif.in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
